// File: rtl/operand_fetch_pkg.sv
// Shared defaults for the operand-fetch stage and its register array.
package operand_fetch_pkg;
   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam bit ZERO_REG_DEF = 1'b1;
   localparam int NUM_REGS     = 2**ADDR_W_DEF;
endpackage

// File: rtl/operand_fetch_reg_array.sv
// 2-read/1-write register storage: combinational reads, synchronous write and clear.
module reg_array
   import operand_fetch_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter bit ZERO_REG = ZERO_REG_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   output logic [DATA_W-1:0] rda,
   output logic [DATA_W-1:0] rdb
);
   localparam int N = 2**ADDR_W;

   logic [DATA_W-1:0] mem [N];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (we && !(ZERO_REG && wa == '0)) begin
         mem[wa] <= wd;
      end
   end

   // Force zero on read too, so reg 0 is clean regardless of any path into it.
   assign rda = (ZERO_REG && ra == '0) ? '0 : mem[ra];
   assign rdb = (ZERO_REG && rb == '0) ? '0 : mem[rb];
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file read with write bypass, stall hold/refresh, flush.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter bit ZERO_REG = ZERO_REG_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] a_data,
   output logic [DATA_W-1:0] b_data
);
   logic [DATA_W-1:0] rda, rdb, opa, opb;
   logic [ADDR_W-1:0] ha, hb;
   logic              wr_ok;

   reg_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rf (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we),
      .wa   (wa),
      .wd   (wd),
      .ra   (ra),
      .rb   (rb),
      .rda  (rda),
      .rdb  (rdb)
   );

   // A write to reg 0 under ZERO_REG never lands, so it must never bypass or refresh.
   assign wr_ok = we && !(ZERO_REG && wa == '0);
   assign opa   = (wr_ok && wa == ra) ? wd : rda;
   assign opb   = (wr_ok && wa == rb) ? wd : rdb;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         a_data    <= '0;
         b_data    <= '0;
         ha        <= '0;
         hb        <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (stall) begin
         if (out_valid && wr_ok && wa == ha) a_data <= wd;
         if (out_valid && wr_ok && wa == hb) b_data <= wd;
      end else if (rd_valid) begin
         out_valid <= 1'b1;
         a_data    <= opa;
         b_data    <= opb;
         ha        <= ra;
         hb        <= rb;
      end else begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipelined operand-fetch stage: a 2-read/1-write register file with a registered output stage.
- Sits directly upstream of the 2:1 operand-select mux in the Project 2 datapath.
- Its registered A/B operands drive the mux's a/b inputs; the downstream stage chooses between them.
- Provides same-cycle write-to-read bypass, stall hold with held-data refresh, and flush.

Parameters:
- DATA_W, 32, width of each register and operand.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.
- ZERO_REG, 1, when 1 register 0 always reads as 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- rd_valid  input  1  read request this cycle.
- ra  input  ADDR_W  operand A source register.
- rb  input  ADDR_W  operand B source register.
- we  input  1  register write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- stall  input  1  hold the output stage; do not accept a new request.
- flush  input  1  kill the output stage contents.
- out_valid  output  1  a_data/b_data are valid.
- a_data  output  DATA_W  registered operand A, to the mux a input.
- b_data  output  DATA_W  registered operand B, to the mux b input.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-low.
- Reset: when rst_n=0 at a clock edge, all registers become 0, out_valid=0, a_data=0 and b_data=0.
- Reset mid-operation: any pending request and any concurrent write are discarded.
- Write: when we=1 at an edge, wd is stored at wa. If ZERO_REG=1 and wa=0, the write is dropped.
- Read latency: exactly 1 cycle.
  - With rd_valid=1, stall=0 and flush=0 at edge N, out_valid=1 and the operands appear after edge N.
  - Read data comes from the register file contents as of that edge.
- Bypass: if we=1 and wa==ra (or wa==rb) at the same edge as an accepted read, the captured operand is wd, not the old contents. This does not apply when ZERO_REG=1 and the address is 0.
- Zero register: when ZERO_REG=1, reading address 0 returns 0 on either port in all cases.
- Idle: with rd_valid=0, stall=0 and flush=0, out_valid becomes 0 at the next edge. a_data and b_data hold their last values.
- Stall: with stall=1 and flush=0, out_valid, a_data and b_data hold, and rd_valid/ra/rb are ignored.
  - Refresh exception: if out_valid=1 and we=1 and wa equals the held A address (nonzero when ZERO_REG=1), a_data takes wd. The same applies to B.
  - To support this, the held ra/rb addresses are stored internally.
- Flush: flush=1 forces out_valid=0 at the next edge, whatever the values of stall and rd_valid. Data registers may hold.
- Flush priority: flush beats stall, and stall beats a new request.
- Write during flush or stall: the register-file write still commits.
- Same address on both ports: ra==rb is legal, and both outputs carry identical data, including the bypass case.
- Address range: all ADDR_W-wide addresses are valid, so no out-of-range case exists.
- Output path: a_data, b_data and out_valid are driven directly from flops, with no combinational path from any input.

Decomposition:
- Shared package or header: DATA_W, ADDR_W and ZERO_REG defaults, plus the localparam NUM_REGS = 2**ADDR_W.
- One sub-module, reg_array.
  - Contains the storage array, two combinational read ports, one synchronous write port and the synchronous active-low reset clear.
- operand_fetch wraps reg_array and adds:
  - bypass comparison,
  - stall/flush control,
  - held-address registers,
  - output flops.

Test Plan:
1. Reset, then write R3=0x0000_00AA. Next cycle, read ra=3, rb=0 -> one cycle later out_valid=1, a_data=0x0000_00AA, b_data=0.
2. Same-edge bypass: R5=0x11 beforehand. Assert we=1, wa=5, wd=0x22 together with rd_valid=1, ra=5, rb=5 -> a_data=b_data=0x22, not 0x11.
3. Stall refresh: out_valid=1 holding ra=7 (a_data=0x70). Assert stall=1 for 3 cycles and write R7=0x77 in cycle 2 -> a_data=0x77 from the following edge; out_valid stays 1; a new request presented during the stall is ignored.
4. Flush with stall: out_valid=1. Assert flush=1 and stall=1 together -> out_valid=0 next edge. A write of R2=0x5 in the same cycle is still visible on a later read of ra=2.
5. Zero register: write R0=0xFFFF_FFFF, then read ra=0 -> a_data=0. Repeat with ZERO_REG=0 -> a_data=0xFFFF_FFFF.
6. Reset mid-stream: issue back-to-back reads with R4=0x44. Deassert rst_n for one edge -> out_valid=0, a_data=b_data=0, and a subsequent read of R4 returns 0.
